// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin arbiter plus a one-deep register stage that feeds the
//   recursive N-to-1 mux. One of 2**S requesters is granted per transfer.
//   The selected word and its index are registered onto out/ctrl with a
//   valid/ready handshake. Back-to-back demand gives one transfer per clock.
//
//   Optional build macro: RR_MUX_BURST_EN
//     When defined, a granted requester keeps priority for up to B
//     consecutive grants while it keeps requesting.
//     When undefined, the pointer advances after every grant and no burst
//     counter is built.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        per-requester request
//   in         packed words; requester i on in[(i+1)*T-1 : i*T]
//   ack        one-hot, combinational; word of requester i taken this cycle
//   ctrl       registered index of the requester whose word is in out
//   out        registered selected word
//   out_valid  out/ctrl hold a word
//   out_ready  downstream accepts out this cycle
module rr_mux_arbiter #(
  parameter int S = 1,
  parameter int T = 8,
  parameter int B = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [(1<<S)-1:0]    req,
  input  logic [(1<<S)*T-1:0]  in,
  output logic [(1<<S)-1:0]    ack,
  output logic [S-1:0]         ctrl,
  output logic [T-1:0]         out,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int N = 1 << S;
  localparam logic [S-1:0] PTR_ONE = S'(1);

  logic [S-1:0] ptr_q, ptr_d;
  logic [S-1:0] gnt_idx;
  logic [S-1:0] scan_idx;
  logic         gnt_found;
  logic         load;

  logic [T-1:0] out_q, out_d;
  logic [S-1:0] ctrl_q, ctrl_d;
  logic         valid_q, valid_d;

  // Rotating priority scan starting at ptr_q; the S-bit add wraps modulo N.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = ptr_q + S'(k);
      if (!gnt_found && req[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  assign load = (|req) && (!valid_q || out_ready);

  // ack is gated by rst_n so nothing is acknowledged while the stage is
  // being cleared.
  assign ack = (load && rst_n) ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;

  always_comb begin
    out_d   = out_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    if (load) begin
      out_d   = in[gnt_idx*T +: T];
      ctrl_d  = gnt_idx;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

`ifdef RR_MUX_BURST_EN
  logic [7:0] cnt_q, cnt_d, cnt_inc;

  // A grant to the requester already holding priority extends its burst.
  // Any other grant starts a fresh burst at 1.
  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    cnt_inc = ((gnt_idx == ptr_q) && (cnt_q != 8'd0)) ? cnt_q + 8'd1 : 8'd1;
    if (load) begin
      if (cnt_inc >= 8'(B)) begin
        ptr_d = gnt_idx + PTR_ONE;
        cnt_d = 8'd0;
      end else begin
        ptr_d = gnt_idx;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end
`else
  always_comb begin
    ptr_d = ptr_q;
    if (load) ptr_d = gnt_idx + PTR_ONE;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      out_q   <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      out_q   <= out_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign ctrl      = ctrl_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter
//   Directed bench for rr_mux_arbiter with S=2, T=8, B=2. Inputs change
//   and outputs are sampled just after the falling edge.
module tb_rr_mux_arbiter;

  localparam int S = 2;
  localparam int T = 8;
  localparam int B = 2;
  localparam int N = 1 << S;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*T-1:0] in;
  logic [N-1:0]   ack;
  logic [S-1:0]   ctrl;
  logic [T-1:0]   out;
  logic           out_valid;
  logic           out_ready;

  int n_checks = 0;
  int n_errors = 0;

  rr_mux_arbiter #(.S(S), .T(T), .B(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in        (in),
    .ack       (ack),
    .ctrl      (ctrl),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 4'b1111;
    in        = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready = 1'b1;

    // Reset holds everything cleared even with all requests up.
    step();
    step();
    chk("rst_ack",   32'(ack), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ctrl",  32'(ctrl), 32'h0);
    chk("rst_out",   32'(out), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ack", 32'(ack), 32'h1);

`ifdef RR_MUX_BURST_EN
    // B=2 burst: 0,0,1,1,0,0 with req=0011.
    req = 4'b0011;
    #1;
    begin
      int exp_g[6] = '{0, 0, 1, 1, 0, 0};
      for (int i = 0; i < 6; i++) begin
        if (i > 0) step();
        chk("burst_ack", 32'(ack), 32'(1 << exp_g[i]));
        if (i > 0) chk("burst_ctrl", 32'(ctrl), 32'(exp_g[i-1]));
      end
    end
    @(negedge clk);
    req = 4'b0001;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      chk("burst_single_ack", 32'(ack), 32'h1);
    end
`else
    // Fairness: all four requesting, one grant per cycle in rotation.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("fair_ctrl",  32'(ctrl), 32'(i % 4));
      chk("fair_out",   32'(out), 32'(8'hA0 + (i % 4)));
      chk("fair_valid", 32'(out_valid), 32'h1);
      chk("fair_ack",   32'(ack), 32'(1 << ((i + 1) % 4)));
    end

    // Backpressure while A1 / ctrl=1 sits in the register.
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) step();
      chk("bp_out",   32'(out), 32'hA1);
      chk("bp_ctrl",  32'(ctrl), 32'h1);
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_ack",   32'(ack), 32'h0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ack", 32'(ack), 32'h4);

    // Wrap/skip with req=1001; pointer is at 3 here.
    @(negedge clk);
    req = 4'b1001;
    #1;
    chk("wrap_ack0",  32'(ack), 32'h8);
    chk("wrap_out0",  32'(out), 32'hA2);
    chk("wrap_ctrl0", 32'(ctrl), 32'h2);
    step();
    chk("wrap_ack1",  32'(ack), 32'h1);
    chk("wrap_ctrl1", 32'(ctrl), 32'h3);
    chk("wrap_out1",  32'(out), 32'hA3);
    step();
    chk("wrap_ack2",  32'(ack), 32'h8);
    chk("wrap_ctrl2", 32'(ctrl), 32'h0);
    chk("wrap_out2",  32'(out), 32'hA0);

    // Drain to idle after the last word (A3 / ctrl=3).
    @(negedge clk);
    req = 4'b0000;
    #1;
    chk("drain_ack0",   32'(ack), 32'h0);
    chk("drain_valid0", 32'(out_valid), 32'h1);
    chk("drain_ctrl0",  32'(ctrl), 32'h3);
    step();
    chk("drain_valid1", 32'(out_valid), 32'h0);
    chk("drain_ctrl1",  32'(ctrl), 32'h3);
    chk("drain_out1",   32'(out), 32'hA3);
    chk("drain_ack1",   32'(ack), 32'h0);

    // Single requester, then a mid-operation reset discards the held word.
    @(negedge clk);
    req = 4'b0010;
    #1;
    chk("single_ack", 32'(ack), 32'h2);
    step();
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_ctrl",  32'(ctrl), 32'h1);
    chk("single_out",   32'(out), 32'hA1);
    chk("single_ack2",  32'(ack), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_out",   32'(out), 32'h0);
    chk("midrst_ctrl",  32'(ctrl), 32'h0);
    chk("midrst_ack",   32'(ack), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_ack", 32'(ack), 32'h2);
    step();
    chk("postrst_ctrl", 32'(ctrl), 32'h1);
    chk("postrst_valid", 32'(out_valid), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and register stage directly upstream of the recursive N-to-1 mux.
- Accepts up to 2**S requesters, each presenting a T-bit word with req/ack. Picks one per transfer, fairly.
- Drives the downstream mux select index on ctrl and presents the selected word on a registered valid/ready output.
- One-cycle latency; sustains one transfer per clock under back-to-back demand.

Parameters:
- S, 1, select width; number of requesters = 2**S (S >= 1).
- T, 8, data word width per requester.
- B, 4, burst limit (1..255); used only when RR_MUX_BURST_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  2**S  requester i has a valid word on its in slice.
- in  input  (2**S)*T  packed words; requester i on in[(i+1)*T-1 : i*T].
- ack  output  2**S  one-hot; requester i's word is taken this cycle (combinational).
- ctrl  output  S  registered index of the requester whose word is in out.
- out  output  T  registered selected word.
- out_valid  output  1  out/ctrl hold a word.
- out_ready  input  1  downstream accepts out this cycle.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out=0, ctrl=0, pointer=0, burst count=0. ack=0 while rst_n=0.
- Internal pointer ptr (S bits) is the highest-priority requester for the next grant.
- load = (|req) && (!out_valid || out_ready). Register slot is free or draining this cycle.
- Grant g = first i with req[i]=1, scanning ptr, ptr+1, ... modulo 2**S (wraps 2**S-1 -> 0).
- ack[g]=1 only when load=1; all other ack bits = 0. ack is combinational from req, out_valid, out_ready and ptr.
- Requesters hold req and data stable until acked. Deasserting req without ack is allowed; no word is taken.
- On the clock edge with load=1:
  - out <= word of g; ctrl <= g; out_valid <= 1.
  - ptr <= g+1 mod 2**S.
- On the clock edge with out_valid && out_ready && !load: out_valid <= 0. out and ctrl keep their last values.
- Simultaneous drain and load: the new word replaces the old in the same edge, giving 100% throughput.
- out_valid && !out_ready: out, ctrl and out_valid stay stable; ack stays 0; ptr stays unchanged.
- Latency: ack cycle N -> word on out with out_valid=1 in cycle N+1.
- Single requester active: it is granted every cycle that load=1.
- Reset mid-operation: a word held in out is discarded. A word acked in the reset-assert cycle is not guaranteed (ack is forced 0 during reset).
- S=1 must elaborate correctly: 2 requesters, 1-bit ctrl.

Optional Feature:
- Macro: RR_MUX_BURST_EN.
- Defined:
  - After a grant to g, ptr stays at g while req[g] remains high and the burst count is < B. Burst count increments per grant to g.
  - When the count reaches B, or g's req drops at a load, ptr <= g+1 and the count resets to 0.
  - Granting a different requester resets the count to 1.
- Undefined: ptr advances after every grant; no counter logic is generated; B is ignored.

Test Plan:
- Reset: rst_n=0 with req=4'b1111, S=2, T=8 -> ack=0, out_valid=0, ctrl=0, out=8'h00. After release with out_ready=1, first ack=4'b0001.
- Fairness: S=2, all req held high, words 8'hA0..8'hA3, out_ready=1 -> ctrl sequence 0,1,2,3,0 on consecutive cycles. out follows A0,A1,A2,A3,A0 with out_valid continuously 1.
- Backpressure: out_ready=0 for 3 cycles while out=8'hA1, ctrl=1 -> out, ctrl and out_valid stable; ack=0 for all 3 cycles. On out_ready=1, a new load occurs in the same cycle.
- Wrap/skip: req=4'b1001, ptr=1 -> grant 3 (ack=4'b1000), then grant 0, then grant 3.
- Drain to idle: req drops to 0 after one word, out_ready=1 -> out_valid falls after 1 cycle. ctrl keeps its last value; ack stays 0.
- RR_MUX_BURST_EN, B=2: req=4'b0011 held -> grants 0,0,1,1,0,0. With only req[0]=1, grants continue on 0 each cycle.
